// File: rtl/sm_tx_mapper.sv
// Spatial-modulation transmit mapper: captures one b1/b2 frame and streams 8
// antenna/slot samples, with only the selected antenna per slot carrying a PAM symbol.
module sm_tx_mapper #(
  parameter int N = 32,
  parameter int Q = 22
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   b1,
  input  logic [3:0]   b2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_r,
  output logic [N-1:0] out_i,
  output logic         out_last,
  output logic         busy
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_cnt;
  logic [7:0] r_b1;
  logic [3:0] r_b2;
  logic       w_capture;
  logic       w_advance;
  logic       w_hit;
  logic [1:0] w_selI;
  logic [1:0] w_selQ;

  // Gray-coded PAM-4: bit 0 picks magnitude (1 or 3), bit 1 picks the sign.
  function automatic logic [N-1:0] pamLevel(input logic [1:0] bits);
    logic [N-1:0] mag;
    mag = bits[0] ? N'(1) : N'(3);
    mag = mag << Q;
    return bits[1] ? mag : -mag;
  endfunction

  assign w_capture = (r_state == IDLE) && in_valid;
  assign w_advance = (r_state == SEND) && out_ready;

  // Counter bit 2 selects the slot, bits 1:0 the antenna within it.
  assign w_hit  = r_cnt[2] ? (r_cnt[1:0] == r_b2[3:2]) : (r_cnt[1:0] == r_b2[1:0]);
  assign w_selI = r_cnt[2] ? r_b1[3:2] : r_b1[7:6];
  assign w_selQ = r_cnt[2] ? r_b1[1:0] : r_b1[5:4];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
      r_b1    <= 8'd0;
      r_b2    <= 4'd0;
    end else begin
      r_state <= w_next;
      if (w_capture) begin
        r_b1  <= b1;
        r_b2  <= b2;
        r_cnt <= 3'd0;
      end else if (w_advance) begin
        r_cnt <= r_cnt + 3'd1;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    out_r     = '0;
    out_i     = '0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_last  = (r_cnt == 3'd7);
        if (w_hit) begin
          out_r = pamLevel(w_selI);
          out_i = pamLevel(w_selQ);
        end
        if (out_ready && (r_cnt == 3'd7)) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: doc/sm_tx_mapper.md
SM_TX_MAPPER -- requirements
Module: sm_tx_mapper

Interface
REQ-001 Parameter N, default 32: sample word width, two's-complement fixed point.
REQ-002 Parameter Q, default 22: fractional bits of every sample word.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  b1/b2 frame offered.
REQ-006 in_ready  output  1  block can accept a frame this cycle.
REQ-007 b1  input  8  PAM bits: [7:6]=I1, [5:4]=Q1, [3:2]=I2, [1:0]=Q2.
REQ-008 b2  input  4  dispersion index q: [1:0]=antenna for slot 0, [3:2]=antenna for slot 1.
REQ-009 out_valid  output  1  out_r/out_i/out_last hold a valid sample.
REQ-010 out_ready  input  1  downstream accepts the sample this cycle.
REQ-011 out_r  output  N  real part of current transmit sample, signed Q-format.
REQ-012 out_i  output  N  imaginary part of current transmit sample, signed Q-format.
REQ-013 out_last  output  1  marks the 8th and final sample of a frame.
REQ-014 busy  output  1  high while a frame is being streamed.

Function
REQ-015 SHALL implement FSM states IDLE and SEND; IDLE after reset.
REQ-016 in_ready SHALL be 1 in IDLE and 0 in SEND.
REQ-017 A frame SHALL be captured on the edge where in_valid && in_ready; b1/b2 registered internally, state -> SEND, sample counter -> 0.
REQ-018 Each 2-bit field SHALL Gray-map to a PAM level: 00 -> -3, 01 -> -1, 11 -> +1, 10 -> +3, each scaled by 2^Q (level << Q) at width N.
REQ-019 Symbols: s1 = I1 + jQ1, s2 = I2 + jQ2.
REQ-020 Sample order SHALL be k = 0..7: k<4 is slot 0, antenna k; k>=4 is slot 1, antenna k-4.
REQ-021 Sample k<4 SHALL equal s1 if k == b2[1:0], else 0 + j0.
REQ-022 Sample k>=4 SHALL equal s2 if (k-4) == b2[3:2], else 0 + j0.
REQ-023 out_valid SHALL be 1 throughout SEND, first asserted the cycle after capture (latency 1).
REQ-024 Counter SHALL advance only on out_valid && out_ready; outputs SHALL hold stable while out_valid && !out_ready.
REQ-025 out_last SHALL be 1 only while counter == 7 in SEND.
REQ-026 Handshake at counter == 7 SHALL return FSM to IDLE; counter wraps to 0; in_ready is 1 next cycle (no back-to-back capture in the same cycle).
REQ-027 in_valid while in SEND SHALL be ignored; captured b1/b2 SHALL not change mid-frame.
REQ-028 busy SHALL equal (state == SEND).
REQ-029 Outside SEND, out_r, out_i and out_last SHALL be 0.
REQ-030 Equal antenna indices b2[1:0] == b2[3:2] are legal and need no special handling.

Reset
REQ-031 rst SHALL force state = IDLE, counter = 0, registered b1/b2 = 0, out_valid = 0, out_last = 0, out_r = out_i = 0, busy = 0, in_ready = 1 on the following cycle.
REQ-032 rst asserted mid-frame SHALL abort and discard the frame; no further samples SHALL be emitted for it.
REQ-033 rst SHALL take priority over a simultaneous in_valid or out_ready.

Verification
REQ-034 b1=8'b10_00_11_01, b2=4'b1001, out_ready=1 -> 8 samples over 8 consecutive cycles; k=1: (0x00C00000, 0xFF400000); k=6: (0x00400000, 0xFFC00000); all other k = (0,0); out_last only at k=7.
REQ-035 b1=8'h00, b2=4'h0, out_ready held 0 for 5 cycles after out_valid rises -> k=0 holds (0xFF400000, 0xFF400000) stable, counter unchanged, then streams normally.
REQ-036 b1=8'hFF, b2=4'b0101 -> k=1 and k=5 both (0x00400000, 0x00400000); others zero.
REQ-037 in_valid held 1 continuously with changing b1/b2 -> exactly one capture per frame, next capture in the cycle after the last handshake, no sample from a mid-frame value.
REQ-038 rst pulsed at k=3 -> next cycle out_valid=0, busy=0, in_ready=1; a new frame then streams from k=0.
REQ-039 Random b1/b2 with random out_ready throttling -> sample stream matches the REQ-018..REQ-022 golden model, with exactly 8 samples and one out_last per frame.
